fsm_top_ctrl: RTL and testbench

Top-level command sequencer that sits directly upstream of the data down-counter (`fsm_dcounter`) in the FSM_TOP_LEVEL group. It decodes single-byte UART commands and issues the counter's `en`/`init_cXX` controls. It uses the returned count to bound each store burst: key, nonce, AD or wave bytes from UART RX into the datapath registers. After an encryption it bounds each flush burst, sending cipher and tag bytes to UART TX.

---
 rtl/fsm_top_ctrl.sv | 159 +++++++++++++++
 tb/tb_fsm_top_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_top_ctrl.sv
// UART command sequencer: decodes commands, drives the down-counter
// controls and bounds the store and flush bursts.
module fsm_top_ctrl (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       tx_ready_i,
  input  logic [8:0] cpt_i,
  input  logic       cipher_done_i,
  output logic       en_o,
  output logic       init_c16_o,
  output logic       init_c17_o,
  output logic       init_c32_o,
  output logic       init_c184_o,
  output logic       init_c366_o,
  output logic       store_key_o,
  output logic       store_nonce_o,
  output logic       store_ad_o,
  output logic       store_wave_o,
  output logic       cipher_start_o,
  output logic       tx_start_o,
  output logic [1:0] tx_sel_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_STORE, S_START, S_WAIT_DONE,
    S_FL_LOAD, S_FL_SEND, S_FL_GAP, S_FL_WAIT
  } state_e;

  typedef enum logic [2:0] {
    K_KEY, K_NONCE, K_AD, K_WAVE, K_CIPHER, K_TAG
  } kind_e;

  state_e state_q, state_d;
  kind_e  kind_q, kind_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      kind_q  <= K_KEY;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    en_o           = 1'b0;
    init_c16_o     = 1'b0;
    init_c17_o     = 1'b0;
    init_c32_o     = 1'b0;
    init_c184_o    = 1'b0;
    init_c366_o    = 1'b0;
    store_key_o    = 1'b0;
    store_nonce_o  = 1'b0;
    store_ad_o     = 1'b0;
    store_wave_o   = 1'b0;
    cipher_start_o = 1'b0;
    tx_start_o     = 1'b0;
    tx_sel_o       = 2'b00;
    busy_o         = 1'b0;
    // Reset masks every strobe, even in the cycle it is raised.
    if (!reset_i) begin
      busy_o = (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          if (rx_valid_i) begin
            case (rx_data_i)
              8'h4B: begin
                kind_d  = K_KEY;
                state_d = S_LOAD;
              end
              8'h4E: begin
                kind_d  = K_NONCE;
                state_d = S_LOAD;
              end
              8'h41: begin
                kind_d  = K_AD;
                state_d = S_LOAD;
              end
              8'h57: begin
                kind_d  = K_WAVE;
                state_d = S_LOAD;
              end
              8'h47:   state_d = S_START;
              default: state_d = S_IDLE;
            endcase
          end
        end
        S_LOAD: begin
          en_o = 1'b1;
          case (kind_q)
            K_AD:    init_c16_o  = 1'b1;
            K_WAVE:  init_c366_o = 1'b1;
            default: init_c32_o  = 1'b1;
          endcase
          state_d = S_STORE;
        end
        S_STORE: begin
          if (rx_valid_i) begin
            en_o = 1'b1;
            case (kind_q)
              K_KEY:   store_key_o   = 1'b1;
              K_NONCE: store_nonce_o = 1'b1;
              K_AD:    store_ad_o    = 1'b1;
              default: store_wave_o  = 1'b1;
            endcase
            if (cpt_i == 9'd1) state_d = S_IDLE;
          end
        end
        S_START: begin
          cipher_start_o = 1'b1;
          state_d        = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (cipher_done_i) begin
            kind_d  = K_CIPHER;
            state_d = S_FL_LOAD;
          end
        end
        S_FL_LOAD: begin
          en_o = 1'b1;
          if (kind_q == K_CIPHER) init_c184_o = 1'b1;
          else                    init_c17_o  = 1'b1;
          state_d = S_FL_SEND;
        end
        S_FL_SEND: begin
          if (tx_ready_i) begin
            tx_start_o = 1'b1;
            en_o       = 1'b1;
            if (cpt_i == 9'd1)          tx_sel_o = 2'b10;
            else if (kind_q == K_CIPHER) tx_sel_o = 2'b01;
            else                         tx_sel_o = 2'b00;
            state_d = S_FL_GAP;
          end
        end
        S_FL_GAP: state_d = S_FL_WAIT;
        S_FL_WAIT: begin
          if (tx_ready_i) begin
            if (cpt_i != 9'd0) begin
              state_d = S_FL_SEND;
            end else if (kind_q == K_CIPHER) begin
              kind_d  = K_TAG;
              state_d = S_FL_LOAD;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_top_ctrl.sv
// Directed bench for fsm_top_ctrl with a behavioural down-counter
// standing in for fsm_dcounter.
module tb_fsm_top_ctrl;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_valid_i = 1'b0;
  logic       tx_ready_i = 1'b0;
  logic [8:0] cpt_i = 9'd0;
  logic       cipher_done_i = 1'b0;
  logic       en_o, init_c16_o, init_c17_o, init_c32_o;
  logic       init_c184_o, init_c366_o;
  logic       store_key_o, store_nonce_o, store_ad_o, store_wave_o;
  logic       cipher_start_o, tx_start_o, busy_o;
  logic [1:0] tx_sel_o;

  fsm_top_ctrl dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_ready_i(tx_ready_i), .cpt_i(cpt_i),
    .cipher_done_i(cipher_done_i), .en_o(en_o),
    .init_c16_o(init_c16_o), .init_c17_o(init_c17_o),
    .init_c32_o(init_c32_o), .init_c184_o(init_c184_o),
    .init_c366_o(init_c366_o), .store_key_o(store_key_o),
    .store_nonce_o(store_nonce_o), .store_ad_o(store_ad_o),
    .store_wave_o(store_wave_o),
    .cipher_start_o(cipher_start_o), .tx_start_o(tx_start_o),
    .tx_sel_o(tx_sel_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  // Down-counter: load values as wired on the real counter.
  always_ff @(posedge clock_i) begin
    if (en_o) begin
      if (init_c16_o)       cpt_i <= 9'd8;
      else if (init_c17_o)  cpt_i <= 9'd17;
      else if (init_c32_o)  cpt_i <= 9'd16;
      else if (init_c184_o) cpt_i <= 9'd185;
      else if (init_c366_o) cpt_i <= 9'd184;
      else                  cpt_i <= cpt_i - 9'd1;
    end
  end

  logic [14:0] outs;
  logic [4:0]  inits;
  logic [3:0]  stores;
  assign inits  = {init_c16_o, init_c17_o, init_c32_o,
                   init_c184_o, init_c366_o};
  assign stores = {store_key_o, store_nonce_o,
                   store_ad_o, store_wave_o};
  assign outs   = {en_o, inits, stores, cipher_start_o,
                   tx_start_o, tx_sel_o, busy_o};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock_i);
    reset_i = 1'b1;
    rx_valid_i = 1'b0;
    cipher_done_i = 1'b0;
    tx_ready_i = 1'b0;
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  task automatic store_burst(input logic [7:0] cmd, input int n,
                             input int sidx,
                             input logic [4:0] exp_init);
    rx_data_i = cmd;
    rx_valid_i = 1'b1;
    #1 chk("cmd_nostore", {stores, en_o}, 0);
    @(negedge clock_i);
    rx_valid_i = 1'b0;
    #1 chk("load_init", {inits, en_o, busy_o}, {exp_init, 2'b11});
    @(negedge clock_i);
    for (int i = 0; i < n; i++) begin
      if (i % 7 == 3) begin
        rx_valid_i = 1'b0;
        #1 chk("store_gap", {stores, en_o, busy_o}, 6'b000001);
        @(negedge clock_i);
      end
      rx_data_i = 8'(i);
      rx_valid_i = 1'b1;
      #1 chk("store", {stores, en_o}, {4'b1000 >> sidx, 1'b1});
      chk("store_cpt", 32'(cpt_i), n - i);
      @(negedge clock_i);
    end
    rx_valid_i = 1'b0;
    #1 chk("busy_after", busy_o, 0);
  endtask

  task automatic run_flush(input int stop_tag);
    int cyc, last, ntx, n01, n00, n10, c17, c184, c32, ncs, gap;
    logic [1:0] sel[$];
    ncs = 0; ntx = 0; n01 = 0; n00 = 0; n10 = 0;
    c17 = 0; c184 = 0; c32 = 0; gap = 1000;
    rx_data_i = 8'h47;
    rx_valid_i = 1'b1;
    #1 @(negedge clock_i);
    rx_valid_i = 1'b0;
    #1 chk("cipher_start", {cipher_start_o, en_o}, 2'b10);
    ncs = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock_i);
      cipher_done_i = (i == 49);
      #1 ncs += int'(cipher_start_o);
    end
    @(negedge clock_i);
    cipher_done_i = 1'b0;
    cyc = 0;
    last = -100;
    while (cyc < 20000) begin
      tx_ready_i = (cyc - last > 20);
      rx_valid_i = (cyc == 300);
      rx_data_i = 8'h4B;
      #1;
      if (tx_start_o) begin
        sel.push_back(tx_sel_o);
        if (cyc - last < gap) gap = cyc - last;
        last = cyc;
        ntx++;
        if (tx_sel_o == 2'b01) n01++;
        else if (tx_sel_o == 2'b00) n00++;
        else if (tx_sel_o == 2'b10) n10++;
      end
      c17 += int'(init_c17_o);
      c184 += int'(init_c184_o);
      c32 += int'(init_c32_o);
      ncs += int'(cipher_start_o);
      if (!busy_o) break;
      if (stop_tag > 0 && ntx == 185 + stop_tag) break;
      @(negedge clock_i);
      cyc++;
    end
    rx_valid_i = 1'b0;
    chk("flush_timeout", cyc < 20000, 1);
    chk("cs_once", ncs, 1);
    chk("c184_once", c184, 1);
    chk("c32_none", c32, 0);
    if (stop_tag == 0) begin
      chk("tx_total", ntx, 202);
      chk("sel01", n01, 184);
      chk("sel00", n00, 16);
      chk("sel10", n10, 2);
      chk("cipher_lf", sel[184], 2'b10);
      chk("tag_lf", sel[201], 2'b10);
      chk("c17_once", c17, 1);
      chk("tx_gap", gap >= 3, 1);
      chk("end_idle", busy_o, 0);
    end else begin
      chk("tag_started", c17, 1);
      @(negedge clock_i);
      reset_i = 1'b1;
      tx_ready_i = 1'b1;
      @(negedge clock_i);
      #1 chk("rst_outs", outs, 0);
      reset_i = 1'b0;
      @(negedge clock_i);
      #1 chk("post_rst_idle", outs, 0);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       busy;
    logic       en;
    logic [4:0] init;
    logic       cs;
    logic [8:0] ld;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{8'h4B, 1'b1, 1'b1, 5'b00100, 1'b0, 9'd16};
    tbl[1] = '{8'h4E, 1'b1, 1'b1, 5'b00100, 1'b0, 9'd16};
    tbl[2] = '{8'h41, 1'b1, 1'b1, 5'b10000, 1'b0, 9'd8};
    tbl[3] = '{8'h57, 1'b1, 1'b1, 5'b00001, 1'b0, 9'd184};
    tbl[4] = '{8'h47, 1'b1, 1'b0, 5'b00000, 1'b1, 9'd0};
    tbl[5] = '{8'h00, 1'b0, 1'b0, 5'b00000, 1'b0, 9'd0};
    tbl[6] = '{8'h5A, 1'b0, 1'b0, 5'b00000, 1'b0, 9'd0};
    tbl[7] = '{8'h0A, 1'b0, 1'b0, 5'b00000, 1'b0, 9'd0};
    tbl[8] = '{8'h6B, 1'b0, 1'b0, 5'b00000, 1'b0, 9'd0};

    do_reset();
    #1 chk("reset_outs", outs, 0);

    foreach (tbl[k]) begin
      do_reset();
      rx_data_i = tbl[k].d;
      rx_valid_i = 1'b1;
      #1 chk("cmd_cycle", outs, 0);
      @(negedge clock_i);
      rx_valid_i = 1'b0;
      #1 chk("decode", {busy_o, en_o, inits, cipher_start_o},
             {tbl[k].busy, tbl[k].en, tbl[k].init, tbl[k].cs});
      if (tbl[k].init != 5'b0) begin
        @(negedge clock_i);
        #1 chk("load_val", 32'(cpt_i), 32'(tbl[k].ld));
      end
    end

    do_reset();
    store_burst(8'h4B, 16, 0, 5'b00100);
    @(negedge clock_i);
    store_burst(8'h41, 8, 2, 5'b10000);
    @(negedge clock_i);
    store_burst(8'h57, 184, 3, 5'b00001);

    do_reset();
    run_flush(0);

    do_reset();
    run_flush(5);
    store_burst(8'h4E, 16, 1, 5'b00100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
